calc1_req_driver: RTL and testbench
===================================

Name: calc1_req_driver

Overview:
- Request-side front end for one calc1 port.
- Accepts an operation (command plus two 32-bit operands) from a host or sequencer over a valid/ready handshake.
- Serialises the operation onto the calc1 two-cycle command/data protocol, then waits for the calc1 response with a timeout.
- Holds the result for the host until it is accepted; one operation is in flight at a time.

Parameters:
- TIMEOUT_CYC, 64, max cycles spent in WAIT before a timeout response is generated (range 1..65535).
- CMD_W, 4, width of the command field.
- DATA_W, 32, operand/result width.

Ports:
- c_clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; when low, all state and outputs go to reset values immediately.
- req_valid  in  1  host presents an operation.
- req_ready  out  1  driver can accept; high only in IDLE.
- req_cmd  in  CMD_W  command: 1 add, 2 sub, 5 shift left, 6 shift right; any other value is forwarded unchanged.
- req_op1  in  DATA_W  first operand.
- req_op2  in  DATA_W  second operand.
- cmd_out  out  CMD_W  calc1 command input.
- data_out  out  DATA_W  calc1 data input.
- resp_in  in  2  calc1 response: 0 none, 1 success, 2 overflow/invalid, 3 internal error.
- out_data_in  in  DATA_W  calc1 result data, qualified by resp_in != 0.
- rsp_valid  out  1  result available to host.
- rsp_ready  in  1  host accepts result.
- rsp_code  out  2  captured resp_in value; 0 when timed out.
- rsp_data  out  DATA_W  captured result; 0 when timed out.
- rsp_timeout  out  1  result produced by timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: req_ready=1, cmd_out=0, data_out=0, rsp_valid=0, rsp_code=0, rsp_data=0, rsp_timeout=0, busy=0; FSM in IDLE; timeout counter 0.
- Outputs cmd_out and data_out are registered.
- IDLE: on req_valid && req_ready, latch req_cmd/op1/op2 and go to CMD.
- CMD (1 cycle): cmd_out=latched cmd, data_out=op1; go to OP2.
- OP2 (1 cycle): cmd_out=0, data_out=op2; go to WAIT; clear counter.
- WAIT:
  - cmd_out=0, data_out=0; counter increments each cycle.
  - When resp_in!=0: capture rsp_code=resp_in and rsp_data=out_data_in, rsp_timeout=0; go to DONE.
  - When the counter reaches TIMEOUT_CYC-1 with resp_in==0: rsp_code=0, rsp_data=0, rsp_timeout=1; go to DONE.
  - A response arriving in the same cycle as the timeout wins; it is captured as a normal response.
- DONE: rsp_valid=1 with rsp_* stable; on rsp_ready, go to IDLE with rsp_valid=0 on the next cycle.
- Any resp_in!=0 in IDLE, CMD, OP2 or DONE is ignored; it is never captured.
- Command 0 is forwarded like any other command and will normally time out.
- Minimum host-to-result latency: accept at edge N, cmd_out at N+1, op2 at N+2, earliest capture at N+3, rsp_valid visible from N+3.
- Back-to-back operation: req_ready returns high the cycle after rsp handshake; no overlap of operations.
- Reset asserted mid-operation aborts immediately. The calc1 bus returns to 0 and no partial response is presented after reset release.

Optional Feature:
- Macro: CALC1_REQ_SCOREBOARD_EN.
- When defined, adds output port exp_mismatch (1 bit, registered, reset 0) and an internal reference model evaluated on the latched request:
  - add: expect code 2 on carry-out, else code 1 with op1+op2.
  - sub: expect code 2 if op2>op1, else code 1 with op1-op2.
  - shl: expect code 1 with op1<<op2[4:0].
  - shr: expect code 1 with op1>>op2[4:0].
  - other commands: expect code 2.
- exp_mismatch is valid while rsp_valid, and is set if rsp_code differs from the expected code, or if the expected code is 1 and rsp_data differs from the expected data.
- On timeout, exp_mismatch=1.
- When the macro is not defined, the port and model are absent and behaviour is otherwise identical.

Test Plan:
- Reset low mid-WAIT with add 5+3 in flight -> all outputs 0 immediately; req_ready=1 after release; a late resp_in=1 is ignored.
- Add 0x00000005+0x00000003; calc1 model returns resp 1/0x8 four cycles after OP2 -> cmd_out=1/data_out=5 then 0/3; rsp_valid with rsp_code=1, rsp_data=0x00000008, rsp_timeout=0.
- Walking-one add: op1=1<<k, op2=0 for k=0..31 -> rsp_data=1<<k each time; req_ready drops for exactly the operation length; rsp_ready held low 3 cycles keeps rsp_* stable.
- Sub 0x1-0x2 with model responding code 2 -> rsp_code=2; with scoreboard enabled, exp_mismatch=0; model forced to respond 1 -> exp_mismatch=1.
- TIMEOUT_CYC=8, no response -> rsp_valid at WAIT entry+8 with rsp_timeout=1, rsp_code=0; a response injected in the timeout cycle -> captured normally with rsp_timeout=0.
- Spurious resp_in=1 during IDLE and CMD -> no rsp_valid; next real response captured correctly.

Source files
------------

// File: rtl/calc1_req_driver.sv
// calc1 request driver: accepts one host op, serialises it onto the calc1 cmd/data bus,
// waits for the response with a timeout. Optional reference check under CALC1_REQ_SCOREBOARD_EN.
module calc1_req_driver #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CMD_W       = 4,
  parameter int DATA_W      = 32
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CMD_W-1:0]  req_cmd,
  input  logic [DATA_W-1:0] req_op1,
  input  logic [DATA_W-1:0] req_op2,
  output logic [CMD_W-1:0]  cmd_out,
  output logic [DATA_W-1:0] data_out,
  input  logic [1:0]        resp_in,
  input  logic [DATA_W-1:0] out_data_in,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_code,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic              busy
`ifdef CALC1_REQ_SCOREBOARD_EN
  ,
  output logic              exp_mismatch
`endif
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_OP2, S_WAIT, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [CMD_W-1:0]  cmd_q;
  logic [DATA_W-1:0] op1_q, op2_q;
  logic [CNT_W-1:0]  cnt;
  logic              resp_hit, to_hit;

  assign resp_hit = (state == S_WAIT) && (resp_in != 2'd0);
  assign to_hit   = (state == S_WAIT) && (resp_in == 2'd0) && (cnt == CNT_LAST);

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_valid) state_nxt = S_CMD;
      S_CMD:  state_nxt = S_OP2;
      S_OP2:  state_nxt = S_WAIT;
      S_WAIT: if (resp_hit || to_hit) state_nxt = S_DONE;
      S_DONE: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    rsp_valid = (state == S_DONE);
  end

  // Bus registers trail the state by one cycle: cmd/op1 appear the cycle after CMD is entered.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      cmd_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      cmd_out     <= '0;
      data_out    <= '0;
      cnt         <= '0;
      rsp_code    <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        cmd_q <= req_cmd;
        op1_q <= req_op1;
        op2_q <= req_op2;
      end
      case (state)
        S_CMD: begin
          cmd_out  <= cmd_q;
          data_out <= op1_q;
        end
        S_OP2: begin
          cmd_out  <= '0;
          data_out <= op2_q;
        end
        default: begin
          cmd_out  <= '0;
          data_out <= '0;
        end
      endcase
      if (state == S_OP2)       cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + 1'b1;
      // A response in the timeout cycle takes priority over the timeout.
      if (resp_hit) begin
        rsp_code    <= resp_in;
        rsp_data    <= out_data_in;
        rsp_timeout <= 1'b0;
      end else if (to_hit) begin
        rsp_code    <= 2'd0;
        rsp_data    <= '0;
        rsp_timeout <= 1'b1;
      end
    end
  end

`ifdef CALC1_REQ_SCOREBOARD_EN
  logic [1:0]        exp_code;
  logic [DATA_W-1:0] exp_data;
  logic [DATA_W:0]   sum;

  always_comb begin
    exp_code = 2'd2;
    exp_data = '0;
    sum      = {1'b0, op1_q} + {1'b0, op2_q};
    case (cmd_q)
      CMD_W'(1): begin
        if (!sum[DATA_W]) begin
          exp_code = 2'd1;
          exp_data = sum[DATA_W-1:0];
        end
      end
      CMD_W'(2): begin
        if (op2_q <= op1_q) begin
          exp_code = 2'd1;
          exp_data = op1_q - op2_q;
        end
      end
      CMD_W'(5): begin
        exp_code = 2'd1;
        exp_data = op1_q << op2_q[4:0];
      end
      CMD_W'(6): begin
        exp_code = 2'd1;
        exp_data = op1_q >> op2_q[4:0];
      end
      default: exp_code = 2'd2;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset)                exp_mismatch <= 1'b0;
    else if (resp_hit)         exp_mismatch <= (resp_in != exp_code) ||
                                               (exp_code == 2'd1 && out_data_in != exp_data);
    else if (to_hit)           exp_mismatch <= 1'b1;
    else if (state == S_IDLE)  exp_mismatch <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_calc1_req_driver.sv
// Directed bench for calc1_req_driver: handshake timing, capture, timeout boundary, reset abort.
module tb_calc1_req_driver;
  localparam int TO = 8;

  logic        c_clk, reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_cmd, cmd_out;
  logic [31:0] req_op1, req_op2, data_out, out_data_in, rsp_data;
  logic [1:0]  resp_in, rsp_code;
  logic        rsp_valid, rsp_ready, rsp_timeout, busy;
`ifdef CALC1_REQ_SCOREBOARD_EN
  logic        exp_mismatch;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  calc1_req_driver #(.TIMEOUT_CYC(TO), .CMD_W(4), .DATA_W(32)) dut (
    .c_clk(c_clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_op1(req_op1), .req_op2(req_op2),
    .cmd_out(cmd_out), .data_out(data_out),
    .resp_in(resp_in), .out_data_in(out_data_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_code(rsp_code),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .busy(busy)
`ifdef CALC1_REQ_SCOREBOARD_EN
    , .exp_mismatch(exp_mismatch)
`endif
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  // dly < 0: calc1 never answers. Otherwise resp driven dly cycles after op2 appears on the bus.
  task automatic do_op(input string tag, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input int dly, input logic [1:0] rc, input logic [31:0] rd, input bit spur,
                       input logic [1:0] ec, input logic [31:0] ed, input bit eto, input bit emm,
                       input int hold);
    int t0;
    bit seen;
    chk({tag, ":ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_cmd = cmd; req_op1 = a; req_op2 = b;
    if (spur) begin resp_in = 2'd1; out_data_in = 32'hdead_beef; end
    tick();
    t0 = cyc;
    req_valid = 1'b0; req_cmd = '0; req_op1 = '0; req_op2 = '0;
    chk({tag, ":ready_drop"}, 32'(req_ready), 32'd0);
    chk({tag, ":busy"}, 32'(busy), 32'd1);
    tick();
    resp_in = 2'd0; out_data_in = '0;
    chk({tag, ":cmd1"}, 32'(cmd_out), 32'(cmd));
    chk({tag, ":op1"}, data_out, a);
    chk({tag, ":no_early_vld"}, 32'(rsp_valid), 32'd0);
    tick();
    chk({tag, ":cmd0"}, 32'(cmd_out), 32'd0);
    chk({tag, ":op2"}, data_out, b);
    if (dly >= 0) begin
      repeat (dly) tick();
      resp_in = rc; out_data_in = rd;
      tick();
      resp_in = 2'd0; out_data_in = '0;
    end
    seen = rsp_valid;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = rsp_valid;
    end
    chk({tag, ":latency"}, seen ? 32'(cyc - t0) : 32'hffff_ffff,
        (dly >= 0) ? 32'(3 + dly) : 32'(2 + TO));
    if (!seen) return;
    chk({tag, ":code"}, 32'(rsp_code), 32'(ec));
    chk({tag, ":data"}, rsp_data, ed);
    chk({tag, ":timeout"}, 32'(rsp_timeout), 32'(eto));
`ifdef CALC1_REQ_SCOREBOARD_EN
    chk({tag, ":mismatch"}, 32'(exp_mismatch), 32'(emm));
`else
    if (emm) ;
`endif
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, ":hold_vld"}, 32'(rsp_valid), 32'd1);
      chk({tag, ":hold_data"}, rsp_data, ed);
      chk({tag, ":hold_code"}, 32'(rsp_code), 32'(ec));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, ":vld_clr"}, 32'(rsp_valid), 32'd0);
    chk({tag, ":ready_back"}, 32'(req_ready), 32'd1);
    chk({tag, ":busy_clr"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_cmd = '0; req_op1 = '0; req_op2 = '0;
    resp_in = '0; out_data_in = '0; rsp_ready = 1'b0;
    #2;
    chk("rst:req_ready", 32'(req_ready), 32'd1);
    chk("rst:cmd_out", 32'(cmd_out), 32'd0);
    chk("rst:data_out", data_out, 32'd0);
    chk("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst:rsp_code", 32'(rsp_code), 32'd0);
    chk("rst:rsp_data", rsp_data, 32'd0);
    chk("rst:rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst:busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Abort mid-WAIT: add 5+3 in flight, op2 still on the bus.
    req_valid = 1'b1; req_cmd = 4'd1; req_op1 = 32'd5; req_op2 = 32'd3;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("abort:pre_data", data_out, 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("abort:cmd_out", 32'(cmd_out), 32'd0);
    chk("abort:data_out", data_out, 32'd0);
    chk("abort:busy", 32'(busy), 32'd0);
    chk("abort:ready", 32'(req_ready), 32'd1);
    chk("abort:rsp_valid", 32'(rsp_valid), 32'd0);
    #1 reset = 1'b1;
    tick();
    resp_in = 2'd1; out_data_in = 32'd8;
    tick();
    resp_in = 2'd0; out_data_in = '0;
    for (int i = 0; i < 3; i++) begin
      chk("abort:late_resp", 32'(rsp_valid), 32'd0);
      tick();
    end
    chk("abort:idle", 32'(req_ready), 32'd1);

    do_op("add5_3", 4'd1, 32'd5, 32'd3, 4, 2'd1, 32'd8, 1'b0, 2'd1, 32'd8, 1'b0, 1'b0, 0);

    for (int k = 0; k < 32; k++)
      do_op("walk1", 4'd1, 32'd1 << k, 32'd0, 1, 2'd1, 32'd1 << k, 1'b0, 2'd1, 32'd1 << k, 1'b0, 1'b0, 3);

    do_op("sub_ovf", 4'd2, 32'd1, 32'd2, 2, 2'd2, 32'd0, 1'b0, 2'd2, 32'd0, 1'b0, 1'b0, 1);
    do_op("sub_bad", 4'd2, 32'd1, 32'd2, 2, 2'd1, 32'hffff_ffff, 1'b0, 2'd1, 32'hffff_ffff, 1'b0, 1'b1, 1);
    do_op("shl", 4'd5, 32'h1, 32'd4, 3, 2'd1, 32'h10, 1'b0, 2'd1, 32'h10, 1'b0, 1'b0, 0);
    do_op("shr", 4'd6, 32'h80, 32'd3, 0, 2'd1, 32'h10, 1'b0, 2'd1, 32'h10, 1'b0, 1'b0, 0);

    do_op("tmo", 4'd0, 32'd5, 32'd3, -1, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b1, 2);
    do_op("tmo_edge", 4'd1, 32'd5, 32'd3, TO - 1, 2'd1, 32'd8, 1'b0, 2'd1, 32'd8, 1'b0, 1'b0, 0);

    resp_in = 2'd1; out_data_in = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("spur_idle:vld", 32'(rsp_valid), 32'd0);
      chk("spur_idle:busy", 32'(busy), 32'd0);
    end
    resp_in = 2'd0; out_data_in = '0;
    do_op("spur_cmd", 4'd1, 32'd2, 32'd2, 2, 2'd1, 32'd4, 1'b1, 2'd1, 32'd4, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
